// File: rtl/fetch_pkg.sv
// Shared widths and the fetch bundle layout used between fetch2 and its queue.
// A bundle entry packs {data, mask, pred, pc} with lane 0 in the most significant word.
package fetch_pkg;

    localparam int INST_W      = 32;
    localparam int PC_W        = 32;
    localparam int FETCH_LANES = 2;

    typedef struct packed {
        logic [FETCH_LANES*INST_W-1:0] data;
        logic [FETCH_LANES-1:0]        mask;
        logic [FETCH_LANES-1:0]        pred;
        logic [PC_W-1:0]               pc;
    } fetch_bundle_t;

    // Packed width of a bundle entry for an arbitrary lane count.
    function automatic int bundle_width(input int lanes);
        return lanes * INST_W + 2 * lanes + PC_W;
    endfunction

endpackage

// File: rtl/bundle_fifo.sv
// Generic DEPTH x W first-word-fall-through FIFO with a synchronous clear.
// Clear and reset both win over push/pop; the storage array itself is never reset.
module bundle_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clr;
    assign do_pop  = pop & ~empty & ~clr;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch2_queue.sv
// Second fetch stage: buffers I-cache bundles, presents the head to decode with
// per-lane masking, and stretches branch flushes to FLUSH_CYCLES cycles.
module fetch2_queue
    import fetch_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic [LANES*INST_W-1:0] idata_i,
    input  logic                    ivalid_i,
    input  logic [LANES-1:0]        lane_mask_i,
    input  logic [LANES-1:0]        pred_i,
    input  logic [PC_W-1:0]         pc_i,
    input  logic                    branch_mispred_i,
    input  logic                    wasnt_branch_i,
    input  logic                    stall_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [LANES*INST_W-1:0] inst_o,
    output logic [LANES-1:0]        pred_o,
    output logic [LANES-1:0]        lane_valid_o,
    output logic [PC_W-1:0]         pc_o,
    output logic                    branch_flush_o
);
    localparam int ENTRY_W = bundle_width(LANES);
    localparam int FC_W    = $clog2(FLUSH_CYCLES + 1);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic                    flush_req;
    logic [FC_W-1:0]         flush_cnt;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [CNT_W-1:0]        count;
    logic [ENTRY_W-1:0]      wr_entry;
    logic [ENTRY_W-1:0]      head;
    logic [LANES*INST_W-1:0] head_data;
    logic [LANES-1:0]        head_mask;
    logic [LANES-1:0]        head_pred;
    logic [PC_W-1:0]         head_pc;

    assign flush_req = branch_mispred_i | wasnt_branch_i;

    // Down-counter: a new request reloads rather than extends the window.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i)
            flush_cnt <= '0;
        else if (flush_req)
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
        else if (flush_cnt != '0)
            flush_cnt <= flush_cnt - 1'b1;
    end

    // While in reset only the live request can raise the flush.
    assign branch_flush_o = flush_req | (reset_n_i & (flush_cnt != '0));
    assign ready_o        = reset_n_i & ~full;
    assign valid_o        = reset_n_i & ~empty & ~branch_flush_o;
    assign push           = ivalid_i & ready_o & ~branch_flush_o;
    assign pop            = valid_o & ~stall_i;
    assign wr_entry       = {idata_i, lane_mask_i, pred_i & lane_mask_i, pc_i};
    assign {head_data, head_mask, head_pred, head_pc} = head;

    bundle_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .clr   (flush_req),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign lane_valid_o = valid_o ? head_mask : '0;
    assign pred_o       = lane_valid_o & head_pred;
    assign pc_o         = valid_o ? head_pc : '0;

    always_comb begin
        inst_o = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_valid_o[k])
                inst_o[(LANES-k)*INST_W-1 -: INST_W] = head_data[(LANES-k)*INST_W-1 -: INST_W];
        end
    end

endmodule
